// File: rtl/mandelbrot_pkg.sv
// Shared types and fixed-point helpers for the escape-time iterator.
package mandelbrot_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ITERATE = 2'd1,
        RESULT  = 2'd2
    } state_t;

    typedef enum logic {
        MODE_MANDELBROT = 1'b0,
        MODE_JULIA      = 1'b1
    } mode_t;

    localparam int THRESH_W = 128;

    // 4.0 expressed in the unshifted product domain (2*frac_bits fractional bits).
    function automatic logic [THRESH_W-1:0] escape_threshold(input int frac_bits);
        logic [THRESH_W-1:0] four;
        four = THRESH_W'(4);
        return four << (2 * frac_bits);
    endfunction

endpackage

// File: rtl/mandelbrot_engine_fxp_complex_square.sv
// Full-precision complex square terms and |z|^2 escape test; purely combinational
// so the multipliers can later be pipelined or mapped to DSP blocks.
module fxp_complex_square
    import mandelbrot_pkg::*;
#(
    parameter int ZW        = 34,
    parameter int FRAC_BITS = 29
) (
    input  logic signed [ZW-1:0]   zr,
    input  logic signed [ZW-1:0]   zi,
    output logic signed [2*ZW-1:0] zr_sq,
    output logic signed [2*ZW-1:0] zi_sq,
    output logic signed [2*ZW-1:0] zr_zi,
    output logic        [2*ZW:0]   mod,
    output logic                   over_four
);

    localparam logic [2*ZW:0] ESC_LIMIT = (2*ZW+1)'(escape_threshold(FRAC_BITS));

    logic signed [2*ZW-1:0] zr_ext;
    logic signed [2*ZW-1:0] zi_ext;

    assign zr_ext = (2*ZW)'(zr);
    assign zi_ext = (2*ZW)'(zi);

    assign zr_sq = zr_ext * zr_ext;
    assign zi_sq = zi_ext * zi_ext;
    assign zr_zi = zr_ext * zi_ext;

    // Both squares are non-negative, so the sum is taken unsigned with one carry bit.
    assign mod       = (2*ZW+1)'($unsigned(zr_sq)) + (2*ZW+1)'($unsigned(zi_sq));
    assign over_four = (mod > ESC_LIMIT);

endmodule

// File: rtl/mandelbrot_engine.sv
// Escape-time iterator for one complex point, Mandelbrot or Julia mode,
// with abort and a valid/ready result handshake.
module mandelbrot_engine
    import mandelbrot_pkg::*;
#(
    parameter int INT_BITS   = 3,
    parameter int FRAC_BITS  = 29,
    parameter int GUARD_BITS = 2,
    parameter int ITER_BITS  = 10
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 req,
    output logic                                 ack,
    input  logic                                 mode,
    input  logic signed [INT_BITS+FRAC_BITS-1:0] x,
    input  logic signed [INT_BITS+FRAC_BITS-1:0] y,
    input  logic signed [INT_BITS+FRAC_BITS-1:0] julia_cr,
    input  logic signed [INT_BITS+FRAC_BITS-1:0] julia_ci,
    input  logic        [ITER_BITS-1:0]          max_iterations,
    input  logic                                 abort,
    output logic                                 busy,
    output logic                                 result_valid,
    input  logic                                 result_ready,
    output logic        [ITER_BITS-1:0]          iteration_count_out,
    output logic                                 escaped
);

    localparam int W  = INT_BITS + FRAC_BITS;
    localparam int ZW = W + GUARD_BITS;

    state_t                 state_reg, state_next;
    logic signed [W-1:0]    c_r_reg, c_r_next;
    logic signed [W-1:0]    c_i_reg, c_i_next;
    logic signed [ZW-1:0]   zr_reg, zr_next;
    logic signed [ZW-1:0]   zi_reg, zi_next;
    logic [ITER_BITS-1:0]   iter_reg, iter_next;
    logic [ITER_BITS-1:0]   max_iter_reg, max_iter_next;
    logic [ITER_BITS-1:0]   count_reg, count_next;
    logic                   escaped_reg, escaped_next;
    logic                   ack_reg, ack_next;
    logic                   valid_reg, valid_next;

    logic signed [2*ZW-1:0] zr_sq, zi_sq, zr_zi;
    logic        [2*ZW:0]   mod;
    logic                   over_four;
    logic signed [2*ZW:0]   sq_diff;
    logic signed [ZW-1:0]   zr_upd, zi_upd;
    logic                   unused_bits;

    fxp_complex_square #(
        .ZW        (ZW),
        .FRAC_BITS (FRAC_BITS)
    ) u_square (
        .zr        (zr_reg),
        .zi        (zi_reg),
        .zr_sq     (zr_sq),
        .zi_sq     (zi_sq),
        .zr_zi     (zr_zi),
        .mod       (mod),
        .over_four (over_four)
    );

    // Part-selects implement the floor-rounding arithmetic shifts truncated to ZW;
    // the doubling of zr*zi is folded into shifting one bit less.
    assign sq_diff = (2*ZW+1)'(zr_sq) - (2*ZW+1)'(zi_sq);
    assign zr_upd  = $signed(sq_diff[FRAC_BITS +: ZW]) + ZW'(c_r_reg);
    assign zi_upd  = $signed(zr_zi[FRAC_BITS-1 +: ZW]) + ZW'(c_i_reg);

    assign unused_bits = ^{sq_diff[2*ZW:FRAC_BITS+ZW], sq_diff[FRAC_BITS-1:0],
                           zr_zi[2*ZW-1:FRAC_BITS-1+ZW], zr_zi[FRAC_BITS-2:0], mod};

    always_comb begin
        state_next    = state_reg;
        c_r_next      = c_r_reg;
        c_i_next      = c_i_reg;
        zr_next       = zr_reg;
        zi_next       = zi_reg;
        iter_next     = iter_reg;
        max_iter_next = max_iter_reg;
        count_next    = count_reg;
        escaped_next  = escaped_reg;
        ack_next      = 1'b0;
        valid_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (req) begin
                    state_next    = ITERATE;
                    ack_next      = 1'b1;
                    iter_next     = '0;
                    max_iter_next = max_iterations;
                    if (mode_t'(mode) == MODE_JULIA) begin
                        c_r_next = julia_cr;
                        c_i_next = julia_ci;
                        zr_next  = ZW'(x);
                        zi_next  = ZW'(y);
                    end else begin
                        c_r_next = x;
                        c_i_next = y;
                        zr_next  = '0;
                        zi_next  = '0;
                    end
                end
            end
            ITERATE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (over_four) begin
                    state_next   = RESULT;
                    escaped_next = 1'b1;
                    count_next   = iter_reg;
                end else if (iter_reg == max_iter_reg) begin
                    state_next   = RESULT;
                    escaped_next = 1'b0;
                    count_next   = iter_reg;
                end else begin
                    zr_next   = zr_upd;
                    zi_next   = zi_upd;
                    iter_next = iter_reg + ITER_BITS'(1);
                end
            end
            RESULT: begin
                // Valid rises on the second RESULT cycle so it is driven from a flop
                // that is already settled when the handshake is evaluated.
                if (abort) begin
                    state_next = IDLE;
                end else if (valid_reg && result_ready) begin
                    state_next = IDLE;
                end else begin
                    valid_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            c_r_reg      <= '0;
            c_i_reg      <= '0;
            zr_reg       <= '0;
            zi_reg       <= '0;
            iter_reg     <= '0;
            max_iter_reg <= '0;
            count_reg    <= '0;
            escaped_reg  <= 1'b0;
            ack_reg      <= 1'b0;
            valid_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            c_r_reg      <= c_r_next;
            c_i_reg      <= c_i_next;
            zr_reg       <= zr_next;
            zi_reg       <= zi_next;
            iter_reg     <= iter_next;
            max_iter_reg <= max_iter_next;
            count_reg    <= count_next;
            escaped_reg  <= escaped_next;
            ack_reg      <= ack_next;
            valid_reg    <= valid_next;
        end
    end

    assign ack                 = ack_reg;
    assign busy                = (state_reg != IDLE);
    assign result_valid        = valid_reg;
    assign iteration_count_out = count_reg;
    assign escaped             = escaped_reg;

endmodule

// File: tb/tb_mandelbrot_engine.sv
// Directed bench for mandelbrot_engine: vector table of jobs plus hand-written
// backpressure, abort and mid-job reset sequences.
module tb_mandelbrot_engine;

    localparam int W  = 32;
    localparam int IB = 10;
    localparam logic signed [W-1:0] ONE = 32'sd536870912;

    typedef struct {
        string               name;
        logic                mode;
        logic signed [W-1:0] x;
        logic signed [W-1:0] y;
        logic signed [W-1:0] jr;
        logic signed [W-1:0] ji;
        logic [IB-1:0]       max_it;
        int                  exp_count;
        logic                exp_esc;
    } vec_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                req = 1'b0;
    logic                ack;
    logic                mode = 1'b0;
    logic signed [W-1:0] x = '0;
    logic signed [W-1:0] y = '0;
    logic signed [W-1:0] julia_cr = '0;
    logic signed [W-1:0] julia_ci = '0;
    logic [IB-1:0]       max_iterations = '0;
    logic                abort = 1'b0;
    logic                busy;
    logic                result_valid;
    logic                result_ready = 1'b1;
    logic [IB-1:0]       iteration_count_out;
    logic                escaped;

    int checks = 0;
    int failures = 0;
    vec_t vecs[7];

    always #5 clk = ~clk;

    mandelbrot_engine dut (
        .clk                 (clk),
        .reset               (reset),
        .req                 (req),
        .ack                 (ack),
        .mode                (mode),
        .x                   (x),
        .y                   (y),
        .julia_cr            (julia_cr),
        .julia_ci            (julia_ci),
        .max_iterations      (max_iterations),
        .abort               (abort),
        .busy                (busy),
        .result_valid        (result_valid),
        .result_ready        (result_ready),
        .iteration_count_out (iteration_count_out),
        .escaped             (escaped)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a job and returns one step after the acceptance edge.
    task automatic start_job(input vec_t v, input logic with_abort);
        mode = v.mode; x = v.x; y = v.y; julia_cr = v.jr; julia_ci = v.ji;
        max_iterations = v.max_it;
        req = 1'b1; abort = with_abort;
        tick();
        req = 1'b0; abort = 1'b0;
        check({v.name, " ack"}, longint'(ack), 1);
        check({v.name, " busy"}, longint'(busy), 1);
        // Scramble the live inputs: the running job must use its latched copies.
        x = $urandom; y = $urandom; julia_cr = $urandom; julia_ci = $urandom;
        max_iterations = IB'($urandom); mode = ~mode;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!result_valid && lat < 400) begin
            tick();
            lat++;
        end
        if (!result_valid) check("result_valid timeout", longint'(result_valid), 1);
    endtask

    task automatic run_job(input vec_t v, input logic with_abort);
        int lat;
        result_ready = 1'b1;
        start_job(v, with_abort);
        wait_valid(lat);
        $display("job %s count=%0d escaped=%0d latency=%0d", v.name,
                 iteration_count_out, escaped, lat);
        check({v.name, " count"}, longint'(iteration_count_out), longint'(v.exp_count));
        check({v.name, " escaped"}, longint'(escaped), longint'(v.exp_esc));
        check({v.name, " latency"}, longint'(lat), longint'(v.exp_count + 2));
        tick();
        check({v.name, " valid after transfer"}, longint'(result_valid), 0);
        check({v.name, " busy after transfer"}, longint'(busy), 0);
    endtask

    initial begin
        int lat;
        logic seen_valid;

        vecs[0] = '{"mb_origin",    1'b0, 32'sd0,  32'sd0, 32'sd0, 32'sd0, 10'd100, 100, 1'b0};
        vecs[1] = '{"mb_two",       1'b0, 2*ONE,   32'sd0, 32'sd0, 32'sd0, 10'd50,  2,   1'b1};
        vecs[2] = '{"mb_one_one",   1'b0, ONE,     ONE,    32'sd0, 32'sd0, 10'd50,  2,   1'b1};
        vecs[3] = '{"mb_minus_two", 1'b0, -2*ONE,  32'sd0, 32'sd0, 32'sd0, 10'd255, 255, 1'b0};
        vecs[4] = '{"julia_1p5",    1'b1, ONE+ONE/2, 32'sd0, 32'sd0, 32'sd0, 10'd20, 1,  1'b1};
        vecs[5] = '{"julia_2p5_m0", 1'b1, 2*ONE+ONE/2, 32'sd0, 32'sd0, 32'sd0, 10'd0, 0, 1'b1};
        vecs[6] = '{"mb_origin_m0", 1'b0, 32'sd0,  32'sd0, 32'sd0, 32'sd0, 10'd0,   0,   1'b0};

        reset = 1'b1;
        repeat (3) tick();
        check("reset ack", longint'(ack), 0);
        check("reset busy", longint'(busy), 0);
        check("reset valid", longint'(result_valid), 0);
        check("reset count", longint'(iteration_count_out), 0);
        check("reset escaped", longint'(escaped), 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) run_job(vecs[i], 1'b0);

        // Backpressure: result held, requests while busy ignored.
        result_ready = 1'b0;
        start_job(vecs[1], 1'b0);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            req = (i % 2 == 0);
            tick();
            check("bp valid", longint'(result_valid), 1);
            check("bp busy", longint'(busy), 1);
            check("bp count", longint'(iteration_count_out), 2);
            check("bp escaped", longint'(escaped), 1);
            check("bp no ack", longint'(ack), 0);
        end
        req = 1'b0;
        result_ready = 1'b1;
        tick();
        $display("backpressure released valid=%0d busy=%0d", result_valid, busy);
        check("bp valid after transfer", longint'(result_valid), 0);
        check("bp busy after transfer", longint'(busy), 0);
        tick();
        check("bp still idle", longint'(busy), 0);
        check("bp single transfer", longint'(result_valid), 0);

        // Abort during ITERATE.
        start_job(vecs[0], 1'b0);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        $display("abort iterate busy=%0d valid=%0d", busy, result_valid);
        check("abort busy", longint'(busy), 0);
        check("abort valid", longint'(result_valid), 0);
        seen_valid = 1'b0;
        repeat (6) begin
            tick();
            seen_valid = seen_valid | result_valid;
        end
        check("abort no late valid", longint'(seen_valid), 0);

        // Abort concurrent with req in IDLE still accepts the job.
        run_job(vecs[2], 1'b1);

        // Abort in RESULT wins over a simultaneous ready.
        result_ready = 1'b0;
        start_job(vecs[1], 1'b0);
        wait_valid(lat);
        abort = 1'b1;
        result_ready = 1'b1;
        tick();
        abort = 1'b0;
        $display("abort result busy=%0d valid=%0d", busy, result_valid);
        check("abort result busy", longint'(busy), 0);
        check("abort result valid", longint'(result_valid), 0);

        // Reset in the middle of a long job, then an immediate new job.
        start_job(vecs[0], 1'b0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        $display("mid reset busy=%0d valid=%0d count=%0d", busy, result_valid, iteration_count_out);
        check("midreset ack", longint'(ack), 0);
        check("midreset busy", longint'(busy), 0);
        check("midreset valid", longint'(result_valid), 0);
        check("midreset count", longint'(iteration_count_out), 0);
        check("midreset escaped", longint'(escaped), 0);
        reset = 1'b0;
        tick();
        run_job(vecs[4], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mandelbrot_engine.md
Name: mandelbrot_engine

Overview:
- Parametrised, second-generation escape-time iterator for a single complex point. Fixed-point format, iteration width and guard bits are configurable.
- Two modes: Mandelbrot (z0 = 0, c = point) and Julia (z0 = point, c = latched constant).
- Adds abort, an escaped/not-escaped flag, and a result valid/ready handshake, so a downstream collector can stall the engine.
- Instantiated N-wide under the frame controller. One instance owns one pixel at a time.

Parameters:
- INT_BITS, 3, signed integer bits of the input coordinate format (including sign).
- FRAC_BITS, 29, fractional bits. Coordinate width W = INT_BITS+FRAC_BITS.
- GUARD_BITS, 2, extra integer bits on internal z registers. ZW = W+GUARD_BITS.
- ITER_BITS, 10, width of iteration limit and count.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  1  start request, sampled in IDLE
- ack  output  1  one-cycle pulse, cycle after acceptance
- mode  input  1  0 = Mandelbrot, 1 = Julia; latched on acceptance
- x  input  W signed  point real part
- y  input  W signed  point imaginary part
- julia_cr  input  W signed  Julia constant, real part; latched
- julia_ci  input  W signed  Julia constant, imaginary part; latched
- max_iterations  input  ITER_BITS  iteration limit; latched
- abort  input  1  cancel current job
- busy  output  1  high in ITERATE and RESULT
- result_valid  output  1  result available
- result_ready  input  1  downstream accepts result
- iteration_count_out  output  ITER_BITS  iterations performed
- escaped  output  1  1 = |z|^2 exceeded 4.0; 0 = limit reached

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: ack=0, busy=0, result_valid=0, iteration_count_out=0, escaped=0, state=IDLE. Reset mid-job discards the job.
- States: IDLE, ITERATE, RESULT.
- IDLE, req=1:
  - latch mode, max_iterations and c.
  - c = (x,y) in Mandelbrot; c = (julia_cr, julia_ci) in Julia.
  - z = 0 in Mandelbrot; z = (x,y) sign-extended to ZW in Julia.
  - iter = 0; ack=1 next cycle; busy=1; go to ITERATE.
- req while busy is ignored; no ack.
- ITERATE, one iteration per cycle:
  - Form full-precision products zr*zr, zi*zi, zr*zi, each 2*ZW bits.
  - mod = zr^2 + zi^2 in 2*ZW+1 bits, compared unshifted against 4.0 << (2*FRAC_BITS). No truncation in the escape test.
  - Priority 1: mod > 4.0 -> escaped=1, count=iter, go to RESULT.
  - Priority 2: else iter == max_iterations -> escaped=0, count=iter, go to RESULT.
  - Otherwise update, using old z on the right-hand side:
    - zr <= ((zr^2 - zi^2) >>> FRAC_BITS) + c_r
    - zi <= ((zr*zi) >>> (FRAC_BITS-1)) + c_i
    - iter++
  - Shift results are truncated to ZW (arithmetic shift, floor rounding).
- Guard bits are sized so the update cannot wrap: |z| < 2 before an update and |c| < 2*sqrt(2) give |z'| < 10 < 2^(INT_BITS+GUARD_BITS-1) at defaults. Inputs with |c| >= 4 are out of contract.
- RESULT:
  - result_valid=1; iteration_count_out and escaped stay stable until result_ready=1.
  - On the cycle valid and ready are both high, the transfer occurs; next cycle result_valid=0, busy=0, state=IDLE.
  - A new req is accepted no earlier than the cycle after return to IDLE.
- Latency: a job accepted at edge k with final count N raises result_valid at edge k+N+2.
- abort=1 in ITERATE or RESULT: next cycle IDLE, busy=0, result_valid=0, no result transfer. abort takes priority over completion and over result_ready in the same cycle. abort in IDLE has no effect. If abort and req are both high in IDLE, the job is accepted.
- max_iterations=0: exactly one escape test, then count=0. escaped=1 only if |z0|^2 > 4.
- Latched configuration: changes to inputs after acceptance have no effect on the running job.

Decomposition:
- mandelbrot_pkg holds:
  - state enum {IDLE, ITERATE, RESULT}
  - mode enum {MODE_MANDELBROT, MODE_JULIA}
  - fixed-point helper function: escape-threshold constant generator parametrised by FRAC_BITS
- Sub-module fxp_complex_square (combinational, ZW and FRAC_BITS parameters). Outputs: full-precision zr^2, zi^2, zr*zi, and mod. This isolates the multipliers for later pipelining or DSP mapping.

Test Plan:
- Mandelbrot c=(0,0), max=100 -> count=100, escaped=0; result_valid at acceptance edge+102.
- Mandelbrot c=(2.0,0), max=50 -> z: 0, 2, 6 -> count=2, escaped=1 (|z|^2=4 exactly does not escape).
- Mandelbrot c=(1.0,1.0), max=50 -> z: (1,1), (1,3) -> count=2, escaped=1. Also c=(-2.0,0), max=255 -> count=255, escaped=0 (no wrap).
- Julia c=(0,0), z0=(1.5,0), max=20 -> count=1, escaped=1. Same with z0=(2.5,0) and max=0 -> count=0, escaped=1.
- Backpressure: hold result_ready=0 for 10 cycles -> outputs stable, busy=1, req pulses ignored (no ack); raise ready -> one transfer, then IDLE.
- Abort at iteration 5 of c=(0,0), max=100 -> busy=0 next cycle, no result_valid. Reset asserted mid-ITERATE -> all outputs at reset values next cycle. An immediate new job completes correctly.
